// File: rtl/axi_lite_reg_router.sv
// axi_lite_reg_router: routes the register interface from axi_lite_slave to
// one of NUM_CLIENTS register banks, selected by address window. Each
// transaction is sequenced: request the client, wait for its strobe (bounded
// by a timeout), then return ack/data/invalid status upstream.
module axi_lite_reg_router #(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int NUM_CLIENTS      = 4,
  parameter int CLIENT_ADDR_BITS = 8,
  parameter int TIMEOUT_CYCLES   = 256
) (
  input  logic                              i_axi_clk,
  input  logic                              i_axi_rst,
  input  logic [ADDR_WIDTH-1:0]             i_reg_address,
  input  logic                              i_reg_in_rdy,
  input  logic [DATA_WIDTH-1:0]             i_reg_in_data,
  output logic                              o_reg_in_ack_stb,
  input  logic                              i_reg_out_req,
  output logic                              o_reg_out_rdy_stb,
  output logic [DATA_WIDTH-1:0]             o_reg_out_data,
  output logic                              o_reg_invalid_addr,
  output logic [CLIENT_ADDR_BITS-1:0]       o_cl_address,
  output logic [DATA_WIDTH-1:0]             o_cl_in_data,
  output logic [NUM_CLIENTS-1:0]            o_cl_in_rdy,
  input  logic [NUM_CLIENTS-1:0]            i_cl_in_ack_stb,
  output logic [NUM_CLIENTS-1:0]            o_cl_out_req,
  input  logic [NUM_CLIENTS-1:0]            i_cl_out_rdy_stb,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] i_cl_out_data,
  input  logic [NUM_CLIENTS-1:0]            i_cl_invalid_addr,
  output logic                              o_timeout_stb
);

  localparam int SEL_BITS = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam int HI_LSB   = CLIENT_ADDR_BITS + SEL_BITS;
  localparam logic [SEL_BITS:0] NUM_CL   = (SEL_BITS+1)'(NUM_CLIENTS);
  // The counter starts at 0 in the first wait cycle, so the last wait cycle
  // is TIMEOUT_CYCLES-1; completing there puts the strobe exactly
  // TIMEOUT_CYCLES cycles after the client request was first asserted.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [SEL_BITS-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_rd_q, done_rd_d;

  logic                        in_ack_d, out_rdy_d, invalid_d, timeout_d;
  logic [DATA_WIDTH-1:0]       rdata_d, wdata_d;
  logic [CLIENT_ADDR_BITS-1:0] addr_d;
  logic [NUM_CLIENTS-1:0]      cl_in_rdy_d, cl_out_req_d;

  // Address decode of the pending upstream request.
  logic [SEL_BITS-1:0]   req_idx;
  logic [ADDR_WIDTH-1:0] hi_bits;
  logic                  req_miss;

  assign req_idx  = i_reg_address[CLIENT_ADDR_BITS +: SEL_BITS];
  assign hi_bits  = i_reg_address >> HI_LSB;
  assign req_miss = ({1'b0, req_idx} >= NUM_CL) || (|hi_bits);

  // Client read data viewed as one word per client.
  logic [DATA_WIDTH-1:0] cl_rdata [NUM_CLIENTS];
  for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_unpack
    assign cl_rdata[k] = i_cl_out_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  logic cnt_expired;
  assign cnt_expired = (cnt_q == CNT_LAST);

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no
    // path through this block leaves a value unassigned and no latch is
    // inferred.
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    done_rd_d    = done_rd_q;
    addr_d       = o_cl_address;
    wdata_d      = o_cl_in_data;
    rdata_d      = o_reg_out_data;
    cl_in_rdy_d  = o_cl_in_rdy;
    cl_out_req_d = o_cl_out_req;
    in_ack_d     = 1'b0;
    out_rdy_d    = 1'b0;
    invalid_d    = 1'b0;
    timeout_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A write wins when both requests arrive together; the held read is
        // picked up once the write has passed through DONE.
        if (i_reg_in_rdy) begin
          done_rd_d = 1'b0;
          if (req_miss) begin
            in_ack_d  = 1'b1;
            invalid_d = 1'b1;
            state_d   = DONE;
          end else begin
            sel_d                = req_idx;
            addr_d               = i_reg_address[CLIENT_ADDR_BITS-1:0];
            wdata_d              = i_reg_in_data;
            cl_in_rdy_d          = '0;
            cl_in_rdy_d[req_idx] = 1'b1;
            cnt_d                = '0;
            state_d              = WR_WAIT;
          end
        end else if (i_reg_out_req) begin
          done_rd_d = 1'b1;
          if (req_miss) begin
            out_rdy_d = 1'b1;
            invalid_d = 1'b1;
            rdata_d   = '0;
            state_d   = DONE;
          end else begin
            sel_d                 = req_idx;
            addr_d                = i_reg_address[CLIENT_ADDR_BITS-1:0];
            cl_out_req_d          = '0;
            cl_out_req_d[req_idx] = 1'b1;
            cnt_d                 = '0;
            state_d               = RD_WAIT;
          end
        end
      end

      WR_WAIT: begin
        // The client strobe is tested first so it wins over an expiring counter.
        if (i_cl_in_ack_stb[sel_q]) begin
          in_ack_d    = 1'b1;
          invalid_d   = i_cl_invalid_addr[sel_q];
          cl_in_rdy_d = '0;
          state_d     = DONE;
        end else if (cnt_expired) begin
          in_ack_d    = 1'b1;
          invalid_d   = 1'b1;
          timeout_d   = 1'b1;
          cl_in_rdy_d = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RD_WAIT: begin
        if (i_cl_out_rdy_stb[sel_q]) begin
          out_rdy_d    = 1'b1;
          invalid_d    = i_cl_invalid_addr[sel_q];
          rdata_d      = cl_rdata[sel_q];
          cl_out_req_d = '0;
          state_d      = DONE;
        end else if (cnt_expired) begin
          out_rdy_d    = 1'b1;
          invalid_d    = 1'b1;
          timeout_d    = 1'b1;
          rdata_d      = '0;
          cl_out_req_d = '0;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        // Leave once the request just served has been released, so a held
        // level cannot re-trigger while a different pending request can
        // still proceed.
        if (done_rd_q ? !i_reg_out_req : !i_reg_in_rdy) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, counter and registered outputs; reset clears all of them.
  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      state_q            <= IDLE;
      sel_q              <= '0;
      cnt_q              <= '0;
      done_rd_q          <= 1'b0;
      o_reg_in_ack_stb   <= 1'b0;
      o_reg_out_rdy_stb  <= 1'b0;
      o_reg_out_data     <= '0;
      o_reg_invalid_addr <= 1'b0;
      o_cl_address       <= '0;
      o_cl_in_data       <= '0;
      o_cl_in_rdy        <= '0;
      o_cl_out_req       <= '0;
      o_timeout_stb      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values of the previous cycle, independent of statement order.
      state_q            <= state_d;
      sel_q              <= sel_d;
      cnt_q              <= cnt_d;
      done_rd_q          <= done_rd_d;
      o_reg_in_ack_stb   <= in_ack_d;
      o_reg_out_rdy_stb  <= out_rdy_d;
      o_reg_out_data     <= rdata_d;
      o_reg_invalid_addr <= invalid_d;
      o_cl_address       <= addr_d;
      o_cl_in_data       <= wdata_d;
      o_cl_in_rdy        <= cl_in_rdy_d;
      o_cl_out_req       <= cl_out_req_d;
      o_timeout_stb      <= timeout_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_router.sv
// Bench for axi_lite_reg_router: directed transactions with a transaction-level
// model of the expected upstream/client outputs, compared every cycle.
module tb_axi_lite_reg_router;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NCL = 4;
  localparam int CAB = 8;
  localparam int T   = 256;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [AW-1:0]      i_reg_address;
  logic               i_reg_in_rdy;
  logic [DW-1:0]      i_reg_in_data;
  logic               o_reg_in_ack_stb;
  logic               i_reg_out_req;
  logic               o_reg_out_rdy_stb;
  logic [DW-1:0]      o_reg_out_data;
  logic               o_reg_invalid_addr;
  logic [CAB-1:0]     o_cl_address;
  logic [DW-1:0]      o_cl_in_data;
  logic [NCL-1:0]     o_cl_in_rdy;
  logic [NCL-1:0]     i_cl_in_ack_stb;
  logic [NCL-1:0]     o_cl_out_req;
  logic [NCL-1:0]     i_cl_out_rdy_stb;
  logic [NCL*DW-1:0]  i_cl_out_data;
  logic [NCL-1:0]     i_cl_invalid_addr;
  logic               o_timeout_stb;

  axi_lite_reg_router #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CLIENTS(NCL),
    .CLIENT_ADDR_BITS(CAB), .TIMEOUT_CYCLES(T)
  ) dut (
    .i_axi_clk         (clk),
    .i_axi_rst         (rst_n),
    .i_reg_address     (i_reg_address),
    .i_reg_in_rdy      (i_reg_in_rdy),
    .i_reg_in_data     (i_reg_in_data),
    .o_reg_in_ack_stb  (o_reg_in_ack_stb),
    .i_reg_out_req     (i_reg_out_req),
    .o_reg_out_rdy_stb (o_reg_out_rdy_stb),
    .o_reg_out_data    (o_reg_out_data),
    .o_reg_invalid_addr(o_reg_invalid_addr),
    .o_cl_address      (o_cl_address),
    .o_cl_in_data      (o_cl_in_data),
    .o_cl_in_rdy       (o_cl_in_rdy),
    .i_cl_in_ack_stb   (i_cl_in_ack_stb),
    .o_cl_out_req      (o_cl_out_req),
    .i_cl_out_rdy_stb  (i_cl_out_rdy_stb),
    .i_cl_out_data     (i_cl_out_data),
    .i_cl_invalid_addr (i_cl_invalid_addr),
    .o_timeout_stb     (o_timeout_stb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs for the current cycle.
  bit             chk_en = 1'b0;
  bit             m_ack, m_rdy, m_inv, m_to;
  logic [DW-1:0]  m_rdata, m_wdata;
  logic [CAB-1:0] m_addr;
  logic [NCL-1:0] m_in_rdy, m_out_req;
  logic [NCL-1:0] seen_in_rdy;

  // Compare process: every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ack",   o_reg_in_ack_stb,   m_ack);
      check("out_rdy",  o_reg_out_rdy_stb,  m_rdy);
      check("invalid",  o_reg_invalid_addr, m_inv);
      check("timeout",  o_timeout_stb,      m_to);
      check("rdata",    o_reg_out_data,     m_rdata);
      check("cl_addr",  o_cl_address,       m_addr);
      check("cl_wdata", o_cl_in_data,       m_wdata);
      check("cl_in",    o_cl_in_rdy,        m_in_rdy);
      check("cl_out",   o_cl_out_req,       m_out_req);
    end
    if (o_cl_in_rdy != '0) seen_in_rdy <= o_cl_in_rdy;
  end

  // Advance one cycle; pulse expectations and client strobes last one cycle.
  task automatic step();
    @(posedge clk);
    #1;
    m_ack = 1'b0; m_rdy = 1'b0; m_inv = 1'b0; m_to = 1'b0;
    i_cl_in_ack_stb   = '0;
    i_cl_out_rdy_stb  = '0;
    i_cl_invalid_addr = '0;
  endtask

  // One upstream transaction. delay = client response cycles after its
  // request appears (negative = never responds). Returns the cycle number of
  // the request cycle; the task ends in the upstream completion cycle.
  task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int delay, input logic [DW-1:0] cdata, input bit cinv,
                        input bit also_rd, output int t0);
    int  idx;
    int  k;
    bit  hit;
    bit  tmo;
    idx = int'(addr / 256);
    hit = (addr / 256) < NCL;
    step();                       // request cycle
    t0 = cyc;
    i_reg_address = addr;
    if (wr) begin
      i_reg_in_rdy  = 1'b1;
      i_reg_in_data = wdata;
    end else begin
      i_reg_out_req = 1'b1;
    end
    if (also_rd) i_reg_out_req = 1'b1;
    step();                       // one cycle later
    if (!hit) begin
      if (wr) m_ack = 1'b1;
      else begin
        m_rdy   = 1'b1;
        m_rdata = '0;
      end
      m_inv = 1'b1;
    end else begin
      m_addr = addr[CAB-1:0];
      if (wr) begin
        m_wdata  = wdata;
        m_in_rdy = NCL'(1 << idx);
      end else begin
        m_out_req = NCL'(1 << idx);
      end
      tmo = (delay < 0) || (delay >= T);
      k   = tmo ? T : delay + 1;
      for (int c = 0; c < k; c++) begin
        if (c > 0) step();
        if (c == 0 && delay != 0) begin
          // Strobes from a client that was not selected must be ignored.
          i_cl_in_ack_stb[(idx+1)%NCL]   = 1'b1;
          i_cl_out_rdy_stb[(idx+1)%NCL]  = 1'b1;
          i_cl_invalid_addr[(idx+1)%NCL] = 1'b1;
        end
        if (!tmo && c == delay) begin
          if (wr) i_cl_in_ack_stb[idx] = 1'b1;
          else begin
            i_cl_out_rdy_stb[idx]         = 1'b1;
            i_cl_out_data[idx*DW +: DW]   = cdata;
          end
          i_cl_invalid_addr[idx] = cinv;
        end
      end
      step();                     // upstream completion cycle
      m_in_rdy  = '0;
      m_out_req = '0;
      if (wr) m_ack = 1'b1;
      else begin
        m_rdy   = 1'b1;
        m_rdata = tmo ? '0 : cdata;
      end
      m_inv = tmo ? 1'b1 : cinv;
      m_to  = tmo;
    end
    if (wr) i_reg_in_rdy = 1'b0;
    else    i_reg_out_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;
    rst_n = 1'b0;
    i_reg_address = '0; i_reg_in_rdy = 1'b0; i_reg_in_data = '0; i_reg_out_req = 1'b0;
    i_cl_in_ack_stb = '0; i_cl_out_rdy_stb = '0; i_cl_out_data = '0; i_cl_invalid_addr = '0;
    m_ack = 1'b0; m_rdy = 1'b0; m_inv = 1'b0; m_to = 1'b0;
    m_rdata = '0; m_wdata = '0; m_addr = '0; m_in_rdy = '0; m_out_req = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack",   o_reg_in_ack_stb, 0);
    check("rst_rdy",   o_reg_out_rdy_stb, 0);
    check("rst_cl_in", o_cl_in_rdy, 0);
    check("rst_cl_out", o_cl_out_req, 0);
    check("rst_rdata", o_reg_out_data, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Write to client 1, acked 3 cycles after its request.
    do_txn(1'b1, 32'h104, 32'hDEADBEEF, 3, '0, 1'b0, 1'b0, t0);
    check("wr1_ack",   o_reg_in_ack_stb, 1);
    check("wr1_inv",   o_reg_invalid_addr, 0);
    check("wr1_lat",   cyc - t0, 5);
    check("wr1_req",   seen_in_rdy, 4'b0010);
    check("wr1_addr",  o_cl_address, 8'h04);
    check("wr1_wdata", o_cl_in_data, 32'hDEADBEEF);
    step();
    check("wr1_ack_width", o_reg_in_ack_stb, 0);

    // Zero-wait read from client 3.
    do_txn(1'b0, 32'h308, '0, 0, 32'h12345678, 1'b0, 1'b0, t0);
    check("rd3_lat",  cyc - t0, 2);
    check("rd3_rdy",  o_reg_out_rdy_stb, 1);
    check("rd3_data", o_reg_out_data, 32'h12345678);

    // Misses: window index out of range, and a high address bit set.
    do_txn(1'b0, 32'h400, '0, 0, '0, 1'b0, 1'b0, t0);
    check("miss_rd_lat",  cyc - t0, 1);
    check("miss_rd_inv",  o_reg_invalid_addr, 1);
    check("miss_rd_data", o_reg_out_data, 0);
    do_txn(1'b1, 32'h8000_0104, 32'h0, 0, '0, 1'b0, 1'b0, t0);
    check("miss_wr_lat", cyc - t0, 1);
    check("miss_wr_ack", o_reg_in_ack_stb, 1);
    check("miss_wr_inv", o_reg_invalid_addr, 1);

    // Client 2 never answers a read.
    do_txn(1'b0, 32'h200, '0, -1, '0, 1'b0, 1'b0, t0);
    check("to_lat",  cyc - t0, 257);
    check("to_stb",  o_timeout_stb, 1);
    check("to_inv",  o_reg_invalid_addr, 1);
    check("to_data", o_reg_out_data, 0);
    step();
    i_cl_out_rdy_stb[2] = 1'b1;   // late strobe, must be ignored
    i_cl_in_ack_stb[2]  = 1'b1;
    step();
    do_txn(1'b0, 32'h2F0, '0, 2, 32'hCAFE0002, 1'b0, 1'b0, t0);
    check("after_to_data", o_reg_out_data, 32'hCAFE0002);
    check("after_to_stb",  o_timeout_stb, 0);

    // Strobe on the last counter cycle wins over the timeout.
    do_txn(1'b1, 32'h3A0, 32'h0BADF00D, T - 1, '0, 1'b0, 1'b0, t0);
    check("edge_lat", cyc - t0, 257);
    check("edge_to",  o_timeout_stb, 0);
    check("edge_inv", o_reg_invalid_addr, 0);

    // Client-reported invalid address on a read.
    do_txn(1'b0, 32'h0FC, '0, 1, 32'hA5A50001, 1'b1, 1'b0, t0);
    check("clinv_inv",  o_reg_invalid_addr, 1);
    check("clinv_data", o_reg_out_data, 32'hA5A50001);

    // Write and read together to client 0: write first, read after DONE.
    do_txn(1'b1, 32'h010, 32'h11112222, 1, '0, 1'b0, 1'b1, t0);
    check("both_wr_ack", o_reg_in_ack_stb, 1);
    check("both_no_rdy", o_reg_out_rdy_stb, 0);
    do_txn(1'b0, 32'h010, '0, 0, 32'h33334444, 1'b0, 1'b0, t1);
    check("both_rd_lat",  cyc - t0, 6);
    check("both_rd_data", o_reg_out_data, 32'h33334444);

    // Reset in the middle of a write wait.
    step();
    i_reg_address = 32'h110; i_reg_in_data = 32'h77778888; i_reg_in_rdy = 1'b1;
    step();
    m_addr = 8'h10; m_wdata = 32'h77778888; m_in_rdy = 4'b0010;
    step();
    rst_n = 1'b0;
    i_reg_in_rdy = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_in_rdy = '0; m_out_req = '0;
    #1;
    check("mid_rst_cl_in", o_cl_in_rdy, 0);
    check("mid_rst_addr",  o_cl_address, 0);
    check("mid_rst_wdata", o_cl_in_data, 0);
    check("mid_rst_rdata", o_reg_out_data, 0);
    step();
    step();
    rst_n = 1'b1;
    do_txn(1'b1, 32'h1F0, 32'h5555AAAA, 0, '0, 1'b0, 1'b0, t0);
    check("post_rst_ack", o_reg_in_ack_stb, 1);
    check("post_rst_lat", cyc - t0, 2);

    repeat (3) step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
